// File: rtl/sunsoft_fme7_mapper.sv
// rtl/sunsoft_fme7_mapper.sv - Sunsoft FME-7 mapper: command/parameter banking, mirroring, CPU-cycle IRQ counter
module sunsoft_fme7_mapper #(
    parameter int PRG_BANK_BITS = 6,
    parameter int CHR_BANK_BITS = 8,
    parameter bit RAM_SUPPORT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [31:0] flags,
    input  logic [15:0] prg_ain,
    input  logic        prg_read,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    input  logic [13:0] chr_ain,
    output logic [21:0] chr_aout,
    output logic        chr_allow,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        irq
);

    logic [3:0]               r_cmd;
    logic [CHR_BANK_BITS-1:0] r_chr_bank [8];
    // index 0 is the $6000 window, 1-3 are $8000/$A000/$C000
    logic [PRG_BANK_BITS-1:0] r_prg_bank [4];
    logic                     r_ram_sel;
    logic                     r_ram_en;
    logic [1:0]               r_mirroring;
    logic                     r_irq_en;
    logic                     r_cnt_en;
    logic [15:0]              r_counter;
    logic                     r_irq;

    logic       w_cmd_write;
    logic       w_param_write;
    logic       w_cnt_load;
    logic       w_irq_ack;
    logic       w_dec;
    logic       w_underflow;
    logic       w_win6;
    logic [8:0] w_prg_bank9;
    logic [9:0] w_chr_bank10;
    logic       w_unused_inputs;

    assign w_cmd_write   = ce & prg_write & (prg_ain[15:13] == 3'b100);
    assign w_param_write = ce & prg_write & (prg_ain[15:13] == 3'b101);
    assign w_cnt_load    = w_param_write & (r_cmd[3:1] == 3'b111);
    assign w_irq_ack     = w_param_write & (r_cmd == 4'hD);
    // A counter load replaces the decrement for that cycle, so it can never underflow
    assign w_dec         = ce & r_cnt_en & ~w_cnt_load;
    assign w_underflow   = w_dec & (r_counter == 16'h0000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd       <= 4'h0;
            for (int i = 0; i < 8; i++) r_chr_bank[i] <= '0;
            for (int i = 0; i < 4; i++) r_prg_bank[i] <= '0;
            r_ram_sel   <= 1'b0;
            r_ram_en    <= 1'b0;
            r_mirroring <= 2'b00;
            r_irq_en    <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_counter   <= 16'h0000;
            r_irq       <= 1'b0;
        end else begin
            if (w_cmd_write) r_cmd <= prg_din[3:0];
            if (w_param_write) begin
                if (!r_cmd[3]) begin
                    r_chr_bank[r_cmd[2:0]] <= CHR_BANK_BITS'(prg_din);
                end else begin
                    case (r_cmd[2:0])
                        3'd0: begin
                            r_ram_en      <= prg_din[7];
                            r_ram_sel     <= prg_din[6] & RAM_SUPPORT;
                            r_prg_bank[0] <= PRG_BANK_BITS'(prg_din[5:0]);
                        end
                        3'd1:    r_prg_bank[1] <= PRG_BANK_BITS'(prg_din);
                        3'd2:    r_prg_bank[2] <= PRG_BANK_BITS'(prg_din);
                        3'd3:    r_prg_bank[3] <= PRG_BANK_BITS'(prg_din);
                        3'd4:    r_mirroring   <= prg_din[1:0];
                        3'd5: begin
                            r_irq_en <= prg_din[0];
                            r_cnt_en <= prg_din[7];
                        end
                        default: ;
                    endcase
                end
            end
            if (w_cnt_load) begin
                if (r_cmd[0]) r_counter[15:8] <= prg_din;
                else          r_counter[7:0]  <= prg_din;
            end else if (w_dec) begin
                r_counter <= r_counter - 16'd1;
            end
            if (w_irq_ack)                    r_irq <= 1'b0;
            else if (w_underflow && r_irq_en) r_irq <= 1'b1;
        end
    end

    assign w_win6 = (prg_ain[15:13] == 3'b011);

    always_comb begin
        w_prg_bank9 = 9'(r_prg_bank[0]);
        case (prg_ain[15:13])
            3'b100:  w_prg_bank9 = 9'(r_prg_bank[1]);
            3'b101:  w_prg_bank9 = 9'(r_prg_bank[2]);
            3'b110:  w_prg_bank9 = 9'(r_prg_bank[3]);
            3'b111:  w_prg_bank9 = 9'({PRG_BANK_BITS{1'b1}});
            default: w_prg_bank9 = 9'(r_prg_bank[0]);
        endcase
        if (w_win6 && r_ram_sel) w_prg_bank9 = 9'h1FF;
    end

    assign prg_aout = {w_prg_bank9, prg_ain[12:0]};

    always_comb begin
        prg_allow = 1'b0;
        if (prg_ain[15])     prg_allow = ~prg_write;
        else if (w_win6)     prg_allow = r_ram_sel ? r_ram_en : ~prg_write;
    end

    assign w_chr_bank10 = 10'(r_chr_bank[chr_ain[12:10]]);
    assign chr_aout     = {2'b10, w_chr_bank10, chr_ain[9:0]};
    assign vram_ce      = chr_ain[13];
    assign chr_allow    = flags[15];
    assign irq          = r_irq;

    always_comb begin
        vram_a10 = chr_ain[10];
        case (r_mirroring)
            2'd0: vram_a10 = chr_ain[10];
            2'd1: vram_a10 = chr_ain[11];
            2'd2: vram_a10 = 1'b0;
            2'd3: vram_a10 = 1'b1;
            default: vram_a10 = chr_ain[10];
        endcase
    end

    assign w_unused_inputs = &{1'b0, flags[31:16], flags[14:0], prg_read};

endmodule

// File: doc/sunsoft_fme7_mapper.md
Name: sunsoft_fme7_mapper

Overview:
Parametrised Sunsoft FME-7 mapper (#69), the successor to our Sunsoft-4 mapper. It uses a command/parameter register pair and provides 8 x 1 kB CHR banks, 3 switchable 8 kB PRG banks and a switchable $6000 window (ROM or PRG RAM). It adds four mirroring modes and a 16-bit CPU-cycle IRQ down-counter. It sits between the CPU/PPU buses and the shared SDRAM address space, like the other mapper modules; the 5B audio extension is out of scope.

Parameters:
PRG_BANK_BITS, 6, width of each PRG bank register (max 9; 6 gives 512 kB).
CHR_BANK_BITS, 8, width of each CHR bank register (max 10; 8 gives 256 kB).
RAM_SUPPORT, 1, 1 enables PRG RAM at $6000; 0 makes the RAM-select bit read as 0.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  CPU-cycle clock enable
flags  in  32  cartridge flags; bit 15 = CHR RAM present
prg_ain  in  16  CPU address
prg_read  in  1  CPU read strobe
prg_write  in  1  CPU write strobe
prg_din  in  8  CPU write data
prg_aout  out  22  PRG memory address
prg_allow  out  1  memory access permitted
chr_ain  in  14  PPU address
chr_aout  out  22  CHR/VRAM memory address
chr_allow  out  1  CHR write permitted
vram_a10  out  1  CIRAM A10
vram_ce  out  1  route to internal VRAM
irq  out  1  IRQ request, active high

Behaviour:
- Reset (async, reset_n=0): cmd=0, all CHR/PRG banks=0, ram_sel=0, ram_en=0, mirroring=0, irq_en=0, cnt_en=0, counter=0, irq=0.
- All register updates are synchronous, gated by ce.
- Write $8000-$9FFF: cmd <= din[3:0].
- Write $A000-$BFFF: update the register selected by cmd.
- Writes to $C000-$FFFF and below $8000 leave registers unchanged. An enabled PRG RAM write is a memory access only.
- cmd 0-7: chr_bank[cmd] <= din[CHR_BANK_BITS-1:0].
- cmd 8: ram_en <= din[7]; ram_sel <= din[6] & RAM_SUPPORT; prg_bank6 <= din[5:0], truncated/zero-extended to PRG_BANK_BITS.
- cmd 9/A/B: PRG bank for $8000/$A000/$C000.
- cmd C: mirroring <= din[1:0].
- cmd D: irq_en <= din[0]; cnt_en <= din[7]; irq <= 0 (acknowledge, every write).
- cmd E/F: counter[7:0] / counter[15:8] <= din.
- Counter: on each ce with cnt_en=1, counter <= counter-1 (mod 2^16). On a 0000->FFFF transition with irq_en=1, irq <= 1 in that cycle. irq then stays high until a cmd D write or reset.
- Counter write (cmd E/F) in the same ce cycle as a decrement: the write wins, there is no decrement that cycle, and no IRQ is raised from it.
- cmd D write coinciding with an underflow: the acknowledge wins, so irq=0. The counter still wraps, using the cnt_en value from before the write.
- PRG mapping (combinational):
  - $E000-$FFFF uses bank all-ones.
  - $8000-$DFFF uses its bank register.
  - ROM address: prg_aout = {zero-pad, bank, prg_ain[12:0]}.
  - $6000-$7FFF with ram_sel=1: prg_aout = {9'h1FF, prg_ain[12:0]}.
  - $6000-$7FFF with ram_sel=0: ROM at prg_bank6.
- prg_allow:
  - $8000-$FFFF: read only.
  - $6000-$7FFF, ram_sel=0: read only.
  - $6000-$7FFF, ram_sel=1: read/write iff ram_en=1.
  - Otherwise 0.
- CHR mapping: chr_ain[13]=0 gives chr_aout = {2'b10, zero-pad, chr_bank[chr_ain[12:10]], chr_ain[9:0]}. chr_ain[13]=1 gives vram_ce=1, and chr_aout is don't-care.
- chr_allow = flags[15].
- vram_a10 by mirroring:
  - 0: chr_ain[10] (vertical)
  - 1: chr_ain[11] (horizontal)
  - 2: 0 (one-screen A)
  - 3: 1 (one-screen B)
- There is no read-side register access, and no latency on address outputs (purely combinational).

Test Plan:
- Reset, then PRG mapping: write $8000=9, $A000=5. Read $8123 -> prg_aout=22'h00A123. Read $E456 -> prg_aout uses bank 6'h3F: 22'h07E456.
- CHR banking: cmd 3 <- 8'hA7. chr_ain=14'h0C55 -> chr_aout = {2'b10, 2'b00, 8'hA7, 10'h055}; vram_ce=0.
- PRG RAM: cmd 8 <- 8'h40 (sel, disabled): write $6010 -> prg_allow=0. cmd 8 <- 8'hC0: write $6010 -> prg_allow=1, prg_aout=22'h3FE010.
- IRQ: counter=16'h0003, cmd D <- 8'h81. The fourth ce later (0000->FFFF) -> irq=1. irq holds through further decrements. cmd D write -> irq=0 the next cycle.
- Collisions and mirroring: cmd E write coinciding with an underflow -> counter = written low byte, irq stays 0. Mirroring 0-3 with chr_ain=14'h2C00 -> vram_a10 = 1, 1, 0, 1. Assert reset_n low mid-count -> irq=0 and counter=0 immediately (async).
